click_decoder: RTL and testbench

- Sits directly downstream of the key debouncer.
- Consumes its one-cycle key-press strobe and groups presses into single, double and triple clicks using an inter-press timeout window.
- Emits one result strobe per group, together with the click count, to the control logic (mode selection, menu stepping).

---
 rtl/click_decoder_pkg.sv | 17 +
 rtl/click_window_timer.sv | 40 ++++
 rtl/click_decoder.sv | 155 +++++++++++++++
 tb/tb_click_decoder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/click_decoder_pkg.sv
// click_decoder_pkg
// Shared types and helpers for the click decoder.
//   state_t            : FSM state encoding (IDLE, COLLECT, REPORT)
//   calc_window_cycles : clock cycles in the inter-press window
package click_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  function automatic int calc_window_cycles(input int clk_freq_mhz, input int window_us);
    return clk_freq_mhz * window_us;
  endfunction

endpackage

// File: rtl/click_window_timer.sv
// click_window_timer
// Counts cycles since the last press of an open group.
// Ports:
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset
//   clear_i  : restart the count at 0 (wins over run_i)
//   run_i    : advance the count while high
//   expire_o : high when the count sits at WINDOW_CYCLES-1 and run_i is high
module click_window_timer #(
  parameter int WINDOW_CYCLES = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);

  logic [TW-1:0] r_count;

  // Window counter; saturates at its last value so it can never wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= {TW{1'b0}};
    end else if (clear_i) begin
      r_count <= {TW{1'b0}};
    end else if (run_i && (r_count != CNT_LAST)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign expire_o = run_i && (r_count == CNT_LAST);

endmodule

// File: rtl/click_decoder.sv
// click_decoder
// Groups debounced key-press strobes into single/double/.../MAX_CLICKS
// clicks using an inter-press timeout window, and reports each group once.
// Ports:
//   clk_i             : system clock
//   rst_i             : asynchronous active-high reset
//   key_pressed_stb_i : one-cycle press strobe from the debouncer
//   click_valid_o     : one-cycle strobe, a group is complete
//   click_count_o     : size of the last completed group (held between strobes)
//   busy_o            : high while a group is open or being reported
module click_decoder
  import click_decoder_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 20,
  parameter int WINDOW_US    = 500,
  parameter int MAX_CLICKS   = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            key_pressed_stb_i,
  output logic                            click_valid_o,
  output logic [$clog2(MAX_CLICKS+1)-1:0] click_count_o,
  output logic                            busy_o
);

  localparam int WINDOW_CYCLES = calc_window_cycles(CLK_FREQ_MHZ, WINDOW_US);
  localparam int CW            = $clog2(MAX_CLICKS + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CLICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CLICKS - 1);

  if ((WINDOW_CYCLES < 2) || (MAX_CLICKS < 2)) begin : g_param_check
    $error("click_decoder: WINDOW_CYCLES and MAX_CLICKS must both be at least 2");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_expire;
  logic          w_timer_clear;
  logic          w_timer_run;
  logic          r_click_valid;
  logic [CW-1:0] r_click_count;
  logic          r_busy;
  logic          w_click_valid_nxt;
  logic [CW-1:0] w_click_count_nxt;
  logic          w_busy_nxt;

  // The window restarts on every press and only runs while a group is open.
  assign w_timer_clear = key_pressed_stb_i || (r_state != COLLECT);
  assign w_timer_run   = (r_state == COLLECT);

  click_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (w_timer_clear),
    .run_i   (w_timer_run),
    .expire_o(w_expire)
  );

  // State and press-count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and next-count logic; a press always beats a timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (key_pressed_stb_i) begin
          w_state_nxt = COLLECT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      COLLECT: begin
        if (key_pressed_stb_i) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = REPORT;
            w_cnt_nxt   = CNT_MAX;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end else if (w_expire) begin
          w_state_nxt = REPORT;
        end else begin
          w_state_nxt = COLLECT;
        end
      end
      REPORT: begin
        // A press during the report cycle opens the next group.
        if (key_pressed_stb_i) begin
          w_state_nxt = COLLECT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so the
  // registered outputs line up with the REPORT cycle.
  always_comb begin
    w_click_valid_nxt = 1'b0;
    w_click_count_nxt = r_click_count;
    w_busy_nxt        = 1'b0;
    if (w_state_nxt == REPORT) begin
      w_click_valid_nxt = 1'b1;
      w_click_count_nxt = w_cnt_nxt;
    end else begin
      w_click_valid_nxt = 1'b0;
      w_click_count_nxt = r_click_count;
    end
    if (w_state_nxt == IDLE) begin
      w_busy_nxt = 1'b0;
    end else begin
      w_busy_nxt = 1'b1;
    end
  end

  // Registered outputs, glitch-free toward the control logic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_click_valid <= 1'b0;
      r_click_count <= {CW{1'b0}};
      r_busy        <= 1'b0;
    end else begin
      r_click_valid <= w_click_valid_nxt;
      r_click_count <= w_click_count_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign click_valid_o = r_click_valid;
  assign click_count_o = r_click_count;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_click_decoder.sv
module tb_click_decoder;

  localparam int W    = 8;
  localparam int MAXC = 3;
  localparam int LEN  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic       valid;
  logic [1:0] count;
  logic       busy;

  click_decoder #(
    .CLK_FREQ_MHZ(1),
    .WINDOW_US   (8),
    .MAX_CLICKS  (3)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .key_pressed_stb_i(stb),
    .click_valid_o    (valid),
    .click_count_o    (count),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  // press[e]: strobe sampled at edge e. exp_*[e]: outputs in the cycle after edge e.
  bit         press [0:LEN];
  bit         exp_v [0:LEN];
  bit         exp_b [0:LEN];
  logic [1:0] exp_c [0:LEN];

  int t;
  bit checking;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", nm, t, act, req);
    end
  endtask

  // Group presses in [lo,hi]: a press joins the group if it comes at most W
  // edges after the previous one; a group ends at MAXC presses or W edges
  // after its last press, and the report is seen in the cycle after that edge.
  task automatic run_segment(input int lo, input int hi);
    int p[$];
    int i, start, last, c, r;
    for (int e = lo; e <= hi; e++) if (press[e]) p.push_back(e);
    i = 0;
    while (i < p.size()) begin
      start = p[i]; last = p[i]; c = 1; i++;
      while (c < MAXC && i < p.size() && p[i] <= last + W) begin
        last = p[i]; c++; i++;
      end
      r = (c == MAXC) ? last : last + W;
      for (int e = start; e <= r && e <= hi; e++) exp_b[e] = 1'b1;
      if (r <= hi) exp_v[r] = 1'b1;
      for (int e = r; e <= hi; e++) exp_c[e] = c[1:0];
    end
  endtask

  task automatic set_press(input int a, input int b, input int c, input int d);
    for (int e = 0; e <= LEN; e++) press[e] = 1'b0;
    if (a > 0) press[a] = 1'b1;
    if (b > 0) press[b] = 1'b1;
    if (c > 0) press[c] = 1'b1;
    if (d > 0) press[d] = 1'b1;
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("valid", int'(valid), int'(exp_v[t]));
      chk("count", int'(count), int'(exp_c[t]));
      chk("busy",  int'(busy),  int'(exp_b[t]));
    end
  end

  // rep_e/rep_c: hand-computed report edge and count; quiet_e: edge with no report.
  task automatic run_test(input int rst_edge, input int rep_e, input int rep_c, input int quiet_e);
    checking = 1'b0;
    stb = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", int'(valid), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_busy",  int'(busy),  0);
    for (int e = 0; e <= LEN; e++) begin
      exp_v[e] = 1'b0; exp_b[e] = 1'b0; exp_c[e] = 2'd0;
    end
    if (rst_edge > 0) begin
      run_segment(1, rst_edge - 1);
      run_segment(rst_edge, LEN);
    end else begin
      run_segment(1, LEN);
    end
    rst = 1'b0;
    t = 0;
    stb = press[1];
    checking = 1'b1;
    for (int k = 1; k <= LEN; k++) begin
      @(posedge clk);
      t = k;
      #1;
      stb = (k < LEN) ? press[k+1] : 1'b0;
      if (k == rep_e) begin
        chk("lit_report_valid", int'(valid), 1);
        chk("lit_report_count", int'(count), rep_c);
      end
      if (k == quiet_e) chk("lit_quiet_valid", int'(valid), 0);
      if (k == rst_edge) begin
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_busy",  int'(busy),  0);
      end
      if (k == rst_edge + 2) begin
        #2;
        rst = 1'b0;
      end
    end
    checking = 1'b0;
  endtask

  initial begin
    // 1: single click, timeout report
    set_press(10, 0, 0, 0);   run_test(-100, 18, 1, 17);
    // 2: double click, no report at the first timeout point
    set_press(10, 15, 0, 0);  run_test(-100, 23, 2, 18);
    // 3: triple click closes at once, fourth press starts a new group
    set_press(10, 12, 14, 16); run_test(-100, 14, 3, 13);
    // 4: second press late in the window still counts
    set_press(10, 17, 0, 0);  run_test(-100, 25, 2, 18);
    // 5: press during the report cycle is not lost
    set_press(10, 19, 0, 0);  run_test(-100, 27, 1, 26);
    // 6: reset mid-group discards it
    set_press(10, 12, 20, 0); run_test(13, 28, 1, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
